// File: rtl/multicycle_control_unit.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/mem/writeback.
// Latency: lw 5, sw/R/addi/andi 4, beq/j/jr 3, illegal 2 cycles; outputs decoded from state register.
// Backpressure: with MULTICYCLE_MEM_WAIT_EN defined, FETCH/MEM_READ/MEM_WRITE hold until mem_ready.
module multicycle_control_unit #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_ANDI  = 6'b001100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       Jr,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUop,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ANDI_EX   = 4'd11,
    S_IMM_WB    = 4'd12
  } state_t;

  state_t cur_state;
  state_t nxt_state;
  logic   mem_ok;

  assign state = cur_state;

`ifdef MULTICYCLE_MEM_WAIT_EN
  // Memory states complete only when the memory signals the access is done.
  assign mem_ok = mem_ready;
`else
  // Memory is assumed single-cycle; mem_ready is deliberately ignored.
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  // State register; reset lands in FETCH immediately, without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= S_FETCH;
    else       cur_state <= nxt_state;
  end

  // Next-state and output decode; every output defaults to 0 for unlisted states.
  always_comb begin
    nxt_state   = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUop       = 2'b00;
    illegal_op  = 1'b0;
    case (cur_state)
      S_FETCH: begin
        // MemRead stays high while waiting; IR and PC only update on completion.
        MemRead   = 1'b1;
        IRWrite   = mem_ok;
        PCWrite   = mem_ok;
        ALUSrcB   = 2'b01;
        nxt_state = mem_ok ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALU speculatively computes the branch target while the opcode is decoded.
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW: nxt_state = S_MEM_ADDR;
          OP_RTYPE:     nxt_state = S_R_EXEC;
          OP_BEQ:       nxt_state = S_BRANCH;
          OP_J:         nxt_state = S_JUMP;
          OP_ADDI:      nxt_state = S_ADDI_EX;
          OP_ANDI:      nxt_state = S_ANDI_EX;
          default: begin
            illegal_op = 1'b1;
            nxt_state  = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        // IR is still stable here, so the opcode picks load vs store.
        nxt_state = (Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        MemRead   = 1'b1;
        IorD      = 1'b1;
        nxt_state = mem_ok ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        nxt_state = S_FETCH;
      end
      S_MEM_WRITE: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        nxt_state = mem_ok ? S_FETCH : S_MEM_WRITE;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
        // jr retires here by loading rs into the PC; no register writeback.
        if (Jr) begin
          PCWrite   = 1'b1;
          PCSource  = 2'b11;
          nxt_state = S_FETCH;
        end else begin
          nxt_state = S_R_WB;
        end
      end
      S_R_WB: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        nxt_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        nxt_state   = S_FETCH;
      end
      S_JUMP: begin
        PCWrite   = 1'b1;
        PCSource  = 2'b10;
        nxt_state = S_FETCH;
      end
      S_ADDI_EX: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        nxt_state = S_IMM_WB;
      end
      S_ANDI_EX: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ALUop     = 2'b11;
        nxt_state = S_IMM_WB;
      end
      S_IMM_WB: begin
        RegWrite  = 1'b1;
        nxt_state = S_FETCH;
      end
      // Encodings 13-15 are unreachable; recover to FETCH with all outputs low.
      default: nxt_state = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class through its state sequence.
// Control outputs are compared as one packed vector per cycle against hand-derived values.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_multicycle_control_unit;

  logic       clk;
  logic       reset;
  logic [5:0] Opcode;
  logic       Jr;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [1:0] ALUSrcB, PCSource, ALUop;
  logic [3:0] state;

  int checks;
  int failures;

  // {illegal_op, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
  //  ALUSrcA, RegWrite, RegDst, ALUSrcB[1:0], PCSource[1:0], ALUop[1:0]}
  logic [16:0] obs;
  assign obs = {illegal_op, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                IRWrite, ALUSrcA, RegWrite, RegDst, ALUSrcB, PCSource, ALUop};

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Jr(Jr), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUop(ALUop), .illegal_op(illegal_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (state !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++;
    if (obs !== 17'h09210) begin failures++; $display("FAIL reset_outputs got=%h exp=09210", obs); end
    tick();
    checks++;
    if (state !== 4'd0) begin failures++; $display("FAIL reset_held_state got=%0d exp=0", state); end
    reset = 1'b0;
  endtask

  task automatic test_lw();
    logic [3:0]  st [6];
    logic [16:0] cv [6];
    st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    cv = '{17'h09210, 17'h00030, 17'h00120, 17'h03000, 17'h00480, 17'h09210};
    Opcode = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (state !== st[i]) begin failures++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state, st[i]); end
      checks++;
      if (obs !== cv[i]) begin failures++; $display("FAIL lw_ctl[%0d] got=%h exp=%h", i, obs, cv[i]); end
      if (i < 5) tick();
    end
  endtask

  task automatic test_sw();
    logic [3:0]  st [5];
    logic [16:0] cv [5];
    st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    cv = '{17'h09210, 17'h00030, 17'h00120, 17'h02800, 17'h09210};
    Opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state !== st[i]) begin failures++; $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, state, st[i]); end
      checks++;
      if (obs !== cv[i]) begin failures++; $display("FAIL sw_ctl[%0d] got=%h exp=%h", i, obs, cv[i]); end
      if (i < 4) tick();
    end
  endtask

  task automatic test_rtype();
    logic [3:0]  st [5];
    logic [16:0] cv [5];
    st = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    cv = '{17'h09210, 17'h00030, 17'h00102, 17'h000C0, 17'h09210};
    Opcode = 6'b000000;
    Jr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state !== st[i]) begin failures++; $display("FAIL rtype_state[%0d] got=%0d exp=%0d", i, state, st[i]); end
      checks++;
      if (obs !== cv[i]) begin failures++; $display("FAIL rtype_ctl[%0d] got=%h exp=%h", i, obs, cv[i]); end
      // Opcode changes after DECODE must neither redirect the FSM nor raise illegal_op.
      if (i == 2) Opcode = 6'b111111;
      if (i < 4) tick();
    end
    Opcode = 6'b000000;
  endtask

  task automatic test_jr();
    logic [3:0]  st [4];
    logic [16:0] cv [4];
    st = '{4'd0, 4'd1, 4'd6, 4'd0};
    cv = '{17'h09210, 17'h00030, 17'h0810E, 17'h09210};
    Opcode = 6'b000000;
    Jr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== st[i]) begin failures++; $display("FAIL jr_state[%0d] got=%0d exp=%0d", i, state, st[i]); end
      checks++;
      if (obs !== cv[i]) begin failures++; $display("FAIL jr_ctl[%0d] got=%h exp=%h", i, obs, cv[i]); end
      if (i < 3) tick();
    end
    Jr = 1'b0;
  endtask

  task automatic test_beq_j();
    logic [3:0]  st [7];
    logic [16:0] cv [7];
    // beq (0,1,8) followed back-to-back by j (0,1,9), ending in FETCH.
    st = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9, 4'd0};
    cv = '{17'h09210, 17'h00030, 17'h04105, 17'h09210, 17'h00030, 17'h08008, 17'h09210};
    Opcode = 6'b000100;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) Opcode = 6'b000010;
      checks++;
      if (state !== st[i]) begin failures++; $display("FAIL beq_j_state[%0d] got=%0d exp=%0d", i, state, st[i]); end
      checks++;
      if (obs !== cv[i]) begin failures++; $display("FAIL beq_j_ctl[%0d] got=%h exp=%h", i, obs, cv[i]); end
      if (i < 6) tick();
    end
  endtask

  task automatic test_imm();
    logic [3:0]  st [9];
    logic [16:0] cv [9];
    // addi (0,1,10,12) then andi (0,1,11,12), ending in FETCH.
    st = '{4'd0, 4'd1, 4'd10, 4'd12, 4'd0, 4'd1, 4'd11, 4'd12, 4'd0};
    cv = '{17'h09210, 17'h00030, 17'h00120, 17'h00080,
           17'h09210, 17'h00030, 17'h00123, 17'h00080, 17'h09210};
    Opcode = 6'b001000;
    for (int i = 0; i < 9; i++) begin
      if (i == 4) Opcode = 6'b001100;
      checks++;
      if (state !== st[i]) begin failures++; $display("FAIL imm_state[%0d] got=%0d exp=%0d", i, state, st[i]); end
      checks++;
      if (obs !== cv[i]) begin failures++; $display("FAIL imm_ctl[%0d] got=%h exp=%h", i, obs, cv[i]); end
      if (i < 8) tick();
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  st [3];
    logic [16:0] cv [3];
    st = '{4'd0, 4'd1, 4'd0};
    cv = '{17'h09210, 17'h10030, 17'h09210};
    Opcode = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (state !== st[i]) begin failures++; $display("FAIL illegal_state[%0d] got=%0d exp=%0d", i, state, st[i]); end
      checks++;
      if (obs !== cv[i]) begin failures++; $display("FAIL illegal_ctl[%0d] got=%h exp=%h", i, obs, cv[i]); end
      if (i < 2) tick();
    end
  endtask

  task automatic test_reset_mid();
    Opcode = 6'b100011;
    tick(); tick(); tick();
    checks++;
    if (state !== 4'd3) begin failures++; $display("FAIL rst_mid_pre got=%0d exp=3", state); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0) begin failures++; $display("FAIL rst_mid_state got=%0d exp=0", state); end
    checks++;
    if (obs !== 17'h09210) begin failures++; $display("FAIL rst_mid_ctl got=%h exp=09210", obs); end
    tick();
    checks++;
    if (state !== 4'd0) begin failures++; $display("FAIL rst_mid_hold got=%0d exp=0", state); end
    reset = 1'b0;
    tick();
    checks++;
    if (state !== 4'd1) begin failures++; $display("FAIL rst_mid_restart got=%0d exp=1", state); end
    tick(); tick(); tick(); tick();
    checks++;
    if (state !== 4'd0) begin failures++; $display("FAIL rst_mid_done got=%0d exp=0", state); end
  endtask

`ifdef MULTICYCLE_MEM_WAIT_EN
  task automatic test_mem_wait();
    Opcode = 6'b101011;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (state !== 4'd0) begin failures++; $display("FAIL wait_fetch_state[%0d] got=%0d exp=0", i, state); end
      checks++;
      if (obs !== 17'h01010) begin failures++; $display("FAIL wait_fetch_ctl[%0d] got=%h exp=01010", i, obs); end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== 17'h09210) begin failures++; $display("FAIL wait_fetch_go got=%h exp=09210", obs); end
    tick();
    checks++;
    if (state !== 4'd1) begin failures++; $display("FAIL wait_decode got=%0d exp=1", state); end
    tick(); tick();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== 4'd5 || obs !== 17'h02800) begin
      failures++; $display("FAIL wait_memwr got=%0d/%h exp=5/02800", state, obs);
    end
    tick();
    checks++;
    if (state !== 4'd5) begin failures++; $display("FAIL wait_memwr_hold got=%0d exp=5", state); end
    mem_ready = 1'b1;
    tick();
    checks++;
    if (state !== 4'd0) begin failures++; $display("FAIL wait_memwr_done got=%0d exp=0", state); end
  endtask
`endif

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    Opcode    = 6'b000000;
    Jr        = 1'b0;
`ifdef MULTICYCLE_MEM_WAIT_EN
    mem_ready = 1'b1;
`else
    // Held low throughout: the default build must ignore it.
    mem_ready = 1'b0;
`endif
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_jr();
    test_beq_j();
    test_imm();
    test_illegal();
    test_reset_mid();
`ifdef MULTICYCLE_MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
